// File: rtl/adder_relation_checker_if.sv
// Request/result bus of the adder relation checker: operands and candidate in,
// satisfied flag and first failing bit index out, each side with valid/ready.
interface adder_relation_checker_if #(
  parameter int W = 8
);
  localparam int IW = $clog2(W + 1);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W:0]    cand_s;
  logic          mode;
  logic          res_valid;
  logic          res_ready;
  logic          res_sat;
  logic [IW-1:0] res_first_bad;

  modport master (
    output in_valid, op_a, op_b, cand_s, mode, res_ready,
    input  in_ready, res_valid, res_sat, res_first_bad
  );

  modport slave (
    input  in_valid, op_a, op_b, cand_s, mode, res_ready,
    output in_ready, res_valid, res_sat, res_first_bad
  );
endinterface

// File: rtl/adder_relation_checker.sv
// Bit-serial checker that a candidate (W+1)-bit result equals a+b or a-b,
// DIGIT bits per cycle, with saturating pass/fail counters.
module adder_relation_checker #(
  parameter int W     = 8,
  parameter int DIGIT = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_relation_checker_if.slave bus,
  input  logic                  clear_cnt,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt
);
  localparam int IW = $clog2(W + 1);
  localparam int S  = W / DIGIT;
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W:0]        cand_q, cand_d;
  logic              mode_q, mode_d;
  logic              carry_q, carry_d;
  logic [SW-1:0]     slice_q, slice_d;
  logic              bad_q, bad_d;
  logic [IW-1:0]     first_bad_q, first_bad_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;

  // Slice datapath: subtraction is a + ~b + 1, the +1 entering as the initial carry.
  logic [DIGIT-1:0]  a_sl, b_sl, c_sl, b_x, mism;
  logic [DIGIT:0]    sum;
  logic              last_slice;
  logic              top_bad;
  logic [IW-1:0]     lo_idx;
  logic [IW-1:0]     abs_idx;

  assign a_sl = a_q[slice_q*DIGIT +: DIGIT];
  assign b_sl = b_q[slice_q*DIGIT +: DIGIT];
  assign c_sl = cand_q[slice_q*DIGIT +: DIGIT];

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      assign b_x[gi]  = b_sl[gi] ^ mode_q;
      assign mism[gi] = sum[gi] ^ c_sl[gi];
    end
  endgenerate

  assign sum        = {1'b0, a_sl} + {1'b0, b_x} + {{DIGIT{1'b0}}, carry_q};
  assign last_slice = (slice_q == SW'(S - 1));
  // Subtract reports a borrow, which is the inverted final carry.
  assign top_bad    = cand_q[W] != (sum[DIGIT] ^ mode_q);

  always_comb begin
    lo_idx = '0;
    for (int j = DIGIT - 1; j >= 0; j--) begin
      if (mism[j]) begin
        lo_idx = IW'(j);
      end
    end
    abs_idx = IW'(int'(slice_q) * DIGIT) + lo_idx;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cand_d      = cand_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    slice_d     = slice_q;
    bad_d       = bad_q;
    first_bad_d = first_bad_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d         = bus.op_a;
          b_d         = bus.op_b;
          cand_d      = bus.cand_s;
          mode_d      = bus.mode;
          carry_d     = bus.mode;
          slice_d     = '0;
          bad_d       = 1'b0;
          first_bad_d = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        carry_d = sum[DIGIT];
        if (!bad_q) begin
          if (|mism) begin
            bad_d       = 1'b1;
            first_bad_d = abs_idx;
          end else if (last_slice && top_bad) begin
            bad_d       = 1'b1;
            first_bad_d = IW'(W);
          end
        end
        if (last_slice) begin
          state_d = DONE;
        end else begin
          slice_d = slice_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear takes priority over the counting handshake.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (clear_cnt) begin
      pass_d = '0;
      fail_d = '0;
    end else if (state_q == DONE && bus.res_ready) begin
      if (bad_q) begin
        if (fail_q != '1) fail_d = fail_q + 1'b1;
      end else begin
        if (pass_q != '1) pass_d = pass_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cand_q      <= '0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      slice_q     <= '0;
      bad_q       <= 1'b0;
      first_bad_q <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cand_q      <= cand_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      slice_q     <= slice_d;
      bad_q       <= bad_d;
      first_bad_q <= first_bad_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.res_valid     = (state_q == DONE);
  assign bus.res_sat       = (state_q == DONE) && !bad_q;
  assign bus.res_first_bad = first_bad_q;
  assign pass_cnt          = pass_q;
  assign fail_cnt          = fail_q;
endmodule

// File: tb/tb_adder_relation_checker.sv
// Directed bench: a default instance plus a CNT_W=2 twin fed the same traffic
// to exercise counter saturation.
module tb_adder_relation_checker;
  logic clk = 1'b0;
  logic rst_n;
  logic clear_cnt;
  logic [15:0] pass_cnt, fail_cnt;
  logic [1:0]  pass_cnt2, fail_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_pass = 0, exp_fail = 0, exp_pass2 = 0, exp_fail2 = 0;

  always #5 clk = ~clk;

  adder_relation_checker_if #(.W(8)) u_if ();
  adder_relation_checker_if #(.W(8)) u_if2 ();

  assign u_if2.in_valid  = u_if.in_valid;
  assign u_if2.op_a      = u_if.op_a;
  assign u_if2.op_b      = u_if.op_b;
  assign u_if2.cand_s    = u_if.cand_s;
  assign u_if2.mode      = u_if.mode;
  assign u_if2.res_ready = u_if.res_ready;

  adder_relation_checker #(.W(8), .DIGIT(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave),
    .clear_cnt(clear_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  adder_relation_checker #(.W(8), .DIGIT(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(u_if2.slave),
    .clear_cnt(clear_cnt), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_counters();
    check("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    check("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
    check("pass_cnt2", 32'(pass_cnt2), 32'(exp_pass2));
    check("fail_cnt2", 32'(fail_cnt2), 32'(exp_fail2));
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] c,
                      input logic m, input logic exp_sat, input logic [3:0] exp_bad,
                      input int hold, input logic clr);
    int lat;
    @(negedge clk);
    u_if.op_a = a; u_if.op_b = b; u_if.cand_s = c; u_if.mode = m;
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    // Scramble the inputs: they must have been captured at the accept edge.
    u_if.op_a = ~a; u_if.op_b = ~b; u_if.cand_s = ~c; u_if.mode = ~m;
    check("busy_in_ready", 32'(u_if.in_ready), 32'd0);
    lat = 0;
    while (!u_if.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("res_sat", 32'(u_if.res_sat), 32'(exp_sat));
    check("first_bad", 32'(u_if.res_first_bad), 32'(exp_bad));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(u_if.res_valid), 32'd1);
      check("hold_sat", 32'(u_if.res_sat), 32'(exp_sat));
      check("hold_first_bad", 32'(u_if.res_first_bad), 32'(exp_bad));
      check("hold_in_ready", 32'(u_if.in_ready), 32'd0);
      check_counters();
    end
    @(negedge clk);
    u_if.res_ready = 1'b1;
    clear_cnt = clr;
    @(posedge clk); #1;
    u_if.res_ready = 1'b0;
    clear_cnt = 1'b0;
    if (clr) begin
      exp_pass = 0; exp_fail = 0; exp_pass2 = 0; exp_fail2 = 0;
    end else if (exp_sat) begin
      exp_pass++;
      if (exp_pass2 < 3) exp_pass2++;
    end else begin
      exp_fail++;
      if (exp_fail2 < 3) exp_fail2++;
    end
    check("after_hs_valid", 32'(u_if.res_valid), 32'd0);
    check_counters();
    $display("txn a=%h b=%h cand=%h mode=%0d sat=%0d first_bad=%0d lat=%0d pass=%0d fail=%0d",
             a, b, c, m, exp_sat, exp_bad, lat, pass_cnt, fail_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_cnt = 1'b0;
    u_if.in_valid = 1'b0; u_if.op_a = '0; u_if.op_b = '0;
    u_if.cand_s = '0; u_if.mode = 1'b0; u_if.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    check("rst_res_valid", 32'(u_if.res_valid), 32'd0);
    check("rst_res_sat", 32'(u_if.res_sat), 32'd0);
    check("rst_first_bad", 32'(u_if.res_first_bad), 32'd0);
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;

    send(8'h5A, 8'h3C, 9'h096, 1'b0, 1'b1, 4'd0, 0, 1'b0);
    send(8'h5A, 8'h3C, 9'h097, 1'b0, 1'b0, 4'd0, 0, 1'b0);
    send(8'h5A, 8'h3C, 9'h196, 1'b0, 1'b0, 4'd8, 0, 1'b0);
    send(8'h10, 8'h01, 9'h00F, 1'b1, 1'b1, 4'd0, 0, 1'b0);
    send(8'h01, 8'h02, 9'h1FF, 1'b1, 1'b1, 4'd0, 0, 1'b0);
    send(8'h01, 8'h02, 9'h0FF, 1'b1, 1'b0, 4'd8, 3, 1'b0);

    // Reset in the middle of a run discards the request and the counters.
    @(negedge clk);
    u_if.op_a = 8'h5A; u_if.op_b = 8'h3C; u_if.cand_s = 9'h096; u_if.mode = 1'b0;
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    u_if.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_in_ready", 32'(u_if.in_ready), 32'd1);
    check("midrst_res_valid", 32'(u_if.res_valid), 32'd0);
    exp_pass = 0; exp_fail = 0; exp_pass2 = 0; exp_fail2 = 0;
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("postrst_no_result", 32'(u_if.res_valid), 32'd0);
    end
    u_if.res_ready = 1'b0;
    check_counters();
    $display("txn reset during RUN: request discarded, counters cleared");

    send(8'hFF, 8'h01, 9'h100, 1'b0, 1'b1, 4'd0, 0, 1'b0);
    send(8'h12, 8'h34, 9'h056, 1'b0, 1'b0, 4'd4, 0, 1'b0);
    send(8'h12, 8'h34, 9'h04A, 1'b0, 1'b0, 4'd2, 0, 1'b0);
    send(8'h00, 8'h00, 9'h000, 1'b0, 1'b1, 4'd0, 0, 1'b0);
    send(8'h80, 8'h80, 9'h100, 1'b0, 1'b1, 4'd0, 0, 1'b0);
    send(8'hFF, 8'hFF, 9'h1FE, 1'b0, 1'b1, 4'd0, 0, 1'b0);
    send(8'hFF, 8'hFF, 9'h000, 1'b1, 1'b1, 4'd0, 0, 1'b0);
    check("sat_pass_cnt2", 32'(pass_cnt2), 32'd3);
    check("unsat_pass_cnt", 32'(pass_cnt), 32'd5);

    // Clear on the same cycle as a failing handshake wins over the increment.
    send(8'h20, 8'h30, 9'h0F0, 1'b1, 1'b0, 4'd8, 0, 1'b1);
    check("clr_fail_cnt", 32'(fail_cnt), 32'd0);
    check("clr_fail_cnt2", 32'(fail_cnt2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
